// File: rtl/jpeg_sched_pkg.sv
// Shared types and constants for the JPEG block scheduler.
// One block is 64 eight-bit samples of an 8x8 tile.
package jpeg_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STRB,
        SEND,
        GAP
    } sched_state_t;

    localparam int BLK_SAMPLES = 64;
    localparam int IDX_W       = 6;
    localparam int SAMPLE_W    = 8;

endpackage

// File: rtl/jpeg_blk_buf.sv
// Single 8x8 block buffer with one write port and one synchronous read port.
// Only the read register is cleared; it reads as zero when no read is issued.
module jpeg_blk_buf
    import jpeg_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem [BLK_SAMPLES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Zero when idle so the encoder sample bus stays quiet outside a replay.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/jpeg_block_scheduler.sv
// Round-robin scheduler sharing one jpeg encoder input among N_REQ block sources.
// Each granted block is captured whole, then replayed as dstrb + 64 contiguous samples.
//
//   state | meaning
//   IDLE  | waiting for any source valid; picks next source round-robin
//   FILL  | accepting 64 bytes from the granted source into the buffer
//   STRB  | one-cycle dstrb to the encoder, first buffer read issued
//   SEND  | 64 back-to-back samples replayed from the buffer
//   GAP   | enforced idle cycles before the next grant
module jpeg_block_scheduler
    import jpeg_sched_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int SRC_W      = 3,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*8-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 dstrb,
    output logic [7:0]           din,
    output logic [SRC_W-1:0]     blk_src,
    output logic                 busy,
    output logic [15:0]          blk_cnt
);

    sched_state_t state, state_n;

    logic [SRC_W-1:0]    rr_ptr, rr_ptr_n;
    logic [SRC_W-1:0]    blk_src_n;
    logic [IDX_W-1:0]    wr_idx, wr_idx_n;
    logic [IDX_W-1:0]    rd_idx, rd_idx_n;
    logic [7:0]          gap_cnt, gap_cnt_n;
    logic [15:0]         blk_cnt_n;
    logic [N_REQ-1:0]    req_ready_n;
    logic                dstrb_n;
    logic                busy_n;

    logic                wr_en;
    logic                rd_en;
    logic                valid_g;
    logic [7:0]          data_g;
    logic [SRC_W:0]      pick;
    logic [SRC_W-1:0]    pick_idx;

    // First valid source at or after the pointer, searched cyclically.
    // The MSB of the result flags that a source was found.
    function automatic logic [SRC_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [SRC_W-1:0] ptr);
        logic [SRC_W:0] res;
        int             idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (valid[idx]) begin
                res = {1'b1, SRC_W'(idx)};
            end
        end
        return res;
    endfunction

    assign pick     = rr_pick(req_valid, rr_ptr);
    assign pick_idx = pick[SRC_W-1:0];

    always_comb begin
        valid_g = 1'b0;
        data_g  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(blk_src) == i) begin
                valid_g = req_valid[i];
                data_g  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        blk_src_n = blk_src;
        wr_idx_n  = wr_idx;
        rd_idx_n  = rd_idx;
        gap_cnt_n = gap_cnt;
        blk_cnt_n = blk_cnt;
        wr_en     = 1'b0;
        rd_en     = 1'b0;

        case (state)
            IDLE: begin
                if (pick[SRC_W]) begin
                    blk_src_n = pick_idx;
                    rr_ptr_n  = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
                    wr_idx_n  = '0;
                    state_n   = FILL;
                end
            end
            FILL: begin
                if (valid_g) begin
                    wr_en    = 1'b1;
                    wr_idx_n = wr_idx + 1'b1;
                    if (wr_idx == IDX_W'(BLK_SAMPLES - 1)) begin
                        state_n = STRB;
                    end
                end
            end
            STRB: begin
                rd_en    = 1'b1;
                rd_idx_n = rd_idx + 1'b1;
                state_n  = SEND;
            end
            SEND: begin
                // rd_idx runs one ahead of the sample on din; it wraps to 0
                // on the cycle presenting the last sample.
                rd_en = (rd_idx != '0);
                if (rd_idx != '0) begin
                    rd_idx_n = rd_idx + 1'b1;
                end
                if (rd_idx == IDX_W'(BLK_SAMPLES - 1)) begin
                    blk_cnt_n = blk_cnt + 16'd1;
                end
                if (rd_idx == '0) begin
                    gap_cnt_n = 8'(GAP_CYCLES);
                    state_n   = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt <= 8'd1) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        dstrb_n = (state_n == STRB);
        busy_n  = (state_n != IDLE);
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_n[i] = (state_n == FILL) && (int'(blk_src_n) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            blk_src   <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            gap_cnt   <= '0;
            blk_cnt   <= '0;
            req_ready <= '0;
            dstrb     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            blk_src   <= blk_src_n;
            wr_idx    <= wr_idx_n;
            rd_idx    <= rd_idx_n;
            gap_cnt   <= gap_cnt_n;
            blk_cnt   <= blk_cnt_n;
            req_ready <= req_ready_n;
            dstrb     <= dstrb_n;
            busy      <= busy_n;
        end
    end

    jpeg_blk_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_idx),
        .wr_data (data_g),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_data (din)
    );

endmodule

// File: tb/tb_jpeg_block_scheduler.sv
// Directed bench for jpeg_block_scheduler: one instance without and one with an
// enforced gap, driven by shared sources that follow the gap-free instance's ready.
module tb_jpeg_block_scheduler;

    localparam int N_REQ = 2;
    localparam int SRC_W = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*8-1:0]   req_data;
    logic [N_REQ-1:0]     req_ready, req_ready_g;
    logic                 dstrb, dstrb_g;
    logic [7:0]           din, din_g;
    logic [SRC_W-1:0]     blk_src, blk_src_g;
    logic                 busy, busy_g;
    logic [15:0]          blk_cnt, blk_cnt_g;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;

    jpeg_block_scheduler #(.N_REQ(N_REQ), .SRC_W(SRC_W), .GAP_CYCLES(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .dstrb     (dstrb),
        .din       (din),
        .blk_src   (blk_src),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
    );

    jpeg_block_scheduler #(.N_REQ(N_REQ), .SRC_W(SRC_W), .GAP_CYCLES(5)) dut_g (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready_g),
        .dstrb     (dstrb_g),
        .din       (din_g),
        .blk_src   (blk_src_g),
        .busy      (busy_g),
        .blk_cnt   (blk_cnt_g)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for dstrb on the selected instance; returns the cycle seen.
    task automatic wait_strb(input bit g, input string tag, output int t);
        int w;
        w = 0;
        while ((g ? dstrb_g : dstrb) !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 32'(g ? dstrb_g : dstrb), 32'd1);
        t = cyc;
    endtask

    // Source s offers 64 bytes from 'first', counting up or down, optionally
    // dropping valid every third cycle. Ready is sampled mid-cycle.
    task automatic drive_src(input int s, input logic [7:0] first, input bit down, input bit bubbles);
        int n;
        int c;
        logic [7:0] b;
        n = 0;
        c = 0;
        b = first;
        while (n < 64 && c < 1000) begin
            @(negedge clk);
            req_valid[s] = !(bubbles && (c % 3 == 2));
            req_data[8*s +: 8] = b;
            if (req_valid[s] && req_ready[s]) begin
                n++;
                last_acc = cyc + 1;
                b = down ? b - 8'd1 : b + 8'd1;
            end
            c++;
        end
        @(negedge clk);
        req_valid[s] = 1'b0;
    endtask

    task automatic watch_block(input logic [7:0] first, input bit down, input int src,
                               input bit chk_lat, input string tag);
        int t0;
        int ts;
        int w;
        logic [7:0] e;
        w = 0;
        while (busy !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        t0 = cyc;
        chk({tag, " ready"}, 32'(req_ready), 32'(1 << src));
        wait_strb(1'b0, {tag, " strb"}, ts);
        if (chk_lat) chk({tag, " strb_latency"}, ts - t0, 64);
        chk({tag, " strb_after_last_byte"}, ts, last_acc);
        chk({tag, " blk_src"}, 32'(blk_src), src);
        e = first;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            chk({tag, " din"}, 32'({dstrb, din}), 32'({1'b0, e}));
            e = down ? e - 8'd1 : e + 8'd1;
        end
        @(negedge clk);
        chk({tag, " idle_after"}, 32'({busy, din}), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int ts;
        int d;
        int bad;
        logic [7:0] exp_b;

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        t         = 0;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'({busy, dstrb, din, blk_src, blk_cnt, req_ready}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_quiet", 32'({busy, dstrb, din, blk_cnt, req_ready}), 32'd0);
        end

        // Single source, continuous 0x00..0x3F
        fork
            drive_src(0, 8'h00, 1'b0, 1'b0);
            watch_block(8'h00, 1'b0, 0, 1'b1, "single");
        join
        chk("single blk_cnt", 32'(blk_cnt), 32'd1);

        // Source 1 with bubbles, 0xFF down to 0xC0
        fork
            drive_src(1, 8'hFF, 1'b1, 1'b1);
            watch_block(8'hFF, 1'b1, 1, 1'b0, "bubble");
        join
        chk("bubble blk_cnt", 32'(blk_cnt), 32'd2);

        // Round robin with both sources always valid
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr cleared blk_cnt", 32'(blk_cnt), 32'd0);
        req_data  = {8'h22, 8'h11};
        req_valid = 2'b11;
        for (int b = 0; b < 4; b++) begin
            wait_strb(1'b0, "rr strb", ts);
            if (b > 0) chk("rr period", ts - t, 130);
            t = ts;
            chk("rr blk_src", 32'(blk_src), b % 2);
            exp_b = (b % 2 == 1) ? 8'h22 : 8'h11;
            bad = 0;
            for (int k = 0; k < 64; k++) begin
                @(negedge clk);
                if (din !== exp_b) bad++;
            end
            chk("rr data_errors", bad, 0);
        end
        chk("rr blk_cnt", 32'(blk_cnt), 32'd4);

        // Gap of 5 cycles on the second instance
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_data  = {8'h00, 8'h33};
        req_valid = 2'b01;
        wait_strb(1'b1, "gap strb", d);
        repeat (64) @(negedge clk);
        chk("gap last_sample", 32'({busy_g, din_g}), 32'({1'b1, 8'h33}));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gap hold", 32'({busy_g, dstrb_g, din_g}), 32'({1'b1, 1'b0, 8'h00}));
        end
        @(negedge clk);
        chk("gap idle", 32'({busy_g, req_ready_g}), 32'd0);
        @(negedge clk);
        chk("gap regrant", 32'({busy_g, req_ready_g}), 32'({1'b1, 2'b01}));
        wait_strb(1'b1, "gap strb2", ts);
        chk("gap period", ts - d, 135);

        // Reset during SEND sample 20 of the gap-free instance
        wait_strb(1'b0, "midrst strb", ts);
        repeat (21) @(negedge clk);
        chk("midrst sample20", 32'({busy, din}), 32'({1'b1, 8'h33}));
        chk("midrst cnt_nonzero", 32'(blk_cnt != 16'd0), 32'd1);
        rst       = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("midrst cleared", 32'({busy, dstrb, din, blk_src, req_ready}), 32'd0);
        chk("midrst blk_cnt", 32'(blk_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst grant_src0", 32'({busy, blk_src, req_ready}), 32'({1'b1, 3'd0, 2'b01}));

        // Counter wrap
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force dut.blk_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.blk_cnt;
        @(negedge clk);
        chk("wrap preset", 32'(blk_cnt), 32'h0000FFFF);
        fork
            drive_src(1, 8'h40, 1'b0, 1'b0);
            watch_block(8'h40, 1'b0, 1, 1'b1, "wrap");
        join
        chk("wrap blk_cnt", 32'(blk_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
